// File: rtl/ctrl_pipe.sv
// Pipelined control unit: decodes the ID opcode into a control bundle, carries it
// through ID/EX, EX/MEM and MEM/WB, and handles load-use holds and redirect squashes.
module ctrl_pipe #(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int UPPER_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [6:0]       id_opcode,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             ex_redirect,
  output logic             stall,
  output logic             flush_ifid,
  output logic             ex_alusrc,
  output logic [1:0]       ex_aluop,
  output logic             ex_branch,
  output logic             ex_jal,
  output logic             ex_jalr,
  output logic             ex_lui,
  output logic             ex_auipc,
  output logic             ex_illegal,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic             ex_memtoreg,
  output logic             ex_regwrite,
  output logic [REG_W-1:0] ex_rd,
  output logic             mem_memread,
  output logic             mem_memwrite,
  output logic             mem_memtoreg,
  output logic             mem_regwrite,
  output logic [REG_W-1:0] mem_rd,
  output logic             wb_memtoreg,
  output logic             wb_regwrite,
  output logic [REG_W-1:0] wb_rd
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef struct packed {
    logic       alusrc;
    logic [1:0] aluop;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       lui;
    logic       auipc;
    logic       illegal;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regwrite;
  } ctl_t;

  typedef struct packed {
    logic memread;
    logic memwrite;
    logic memtoreg;
    logic regwrite;
  } mctl_t;

  typedef enum logic {RUN, HOLD} state_t;

  function automatic ctl_t decode(input logic [6:0] op);
    ctl_t c;
    c = '0;
    unique case (op)
      OP_R:    begin c.regwrite = 1'b1; c.aluop = 2'b10; end
      OP_I:    begin c.alusrc = 1'b1; c.regwrite = 1'b1; c.aluop = 2'b10; end
      OP_LW:   begin
        c.alusrc   = 1'b1;
        c.memread  = 1'b1;
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      OP_SW:   begin c.alusrc = 1'b1; c.memwrite = 1'b1; end
      OP_BR:   begin c.branch = 1'b1; c.aluop = 2'b01; end
      OP_JAL:  begin c.jal = 1'b1; c.regwrite = 1'b1; end
      OP_JALR: begin c.jalr = 1'b1; c.alusrc = 1'b1; c.regwrite = 1'b1; end
      OP_LUI:  begin
        if (UPPER_EN != 0) begin
          c.lui = 1'b1; c.alusrc = 1'b1; c.regwrite = 1'b1;
        end else begin
          c.illegal = 1'b1;
        end
      end
      OP_AUIPC: begin
        if (UPPER_EN != 0) begin
          c.auipc = 1'b1; c.alusrc = 1'b1; c.regwrite = 1'b1;
        end else begin
          c.illegal = 1'b1;
        end
      end
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  function automatic logic uses_rs1(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BR) || (op == OP_JALR);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_R) || (op == OP_SW) || (op == OP_BR);
  endfunction

  ctl_t             ctl_p0;
  logic             use1_p0;
  logic             use2_p0;
  logic             hz;
  logic             bubble;
  state_t           state;
  state_t           state_nxt;
  logic [1:0]       cnt;
  logic [1:0]       cnt_nxt;

  ctl_t             ctl_p1;
  logic [REG_W-1:0] rd_p1;
  logic             vld_p1;
  mctl_t            mctl_p2;
  logic [REG_W-1:0] rd_p2;
  logic             vld_p2;
  logic             memtoreg_p3;
  logic             regwrite_p3;
  logic [REG_W-1:0] rd_p3;
  logic             vld_p3;

  // ID stage: decode and load-use detection against the instruction in EX
  always_comb begin
    ctl_p0  = '0;
    use1_p0 = 1'b0;
    use2_p0 = 1'b0;
    if (id_valid) begin
      ctl_p0  = decode(id_opcode);
      use1_p0 = uses_rs1(id_opcode);
      use2_p0 = uses_rs2(id_opcode);
    end
  end

  assign hz = ctl_p1.memread && (rd_p1 != '0) && id_valid &&
              ((use1_p0 && (id_rs1 == rd_p1)) || (use2_p0 && (id_rs2 == rd_p1)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (ex_redirect) begin
      state_nxt = RUN;
      cnt_nxt   = 2'd0;
    end else begin
      unique case (state)
        RUN: begin
          if (hz && (LOAD_LAT > 1)) begin
            state_nxt = HOLD;
            cnt_nxt   = 2'(LOAD_LAT - 1);
          end
        end
        HOLD: begin
          if (cnt == 2'd1) begin
            state_nxt = RUN;
            cnt_nxt   = 2'd0;
          end else begin
            cnt_nxt = cnt - 2'd1;
          end
        end
        default: begin
          state_nxt = RUN;
          cnt_nxt   = 2'd0;
        end
      endcase
    end
  end

  // A redirect squashes whatever ID holds, so it wins over any pending hold
  always_comb begin
    stall      = 1'b0;
    flush_ifid = ex_redirect;
    bubble     = 1'b0;
    if (ex_redirect) begin
      bubble = 1'b1;
    end else begin
      unique case (state)
        RUN:  begin stall = hz;   bubble = hz;   end
        HOLD: begin stall = 1'b1; bubble = 1'b1; end
        default: begin stall = 1'b0; bubble = 1'b0; end
      endcase
    end
  end

  // ID/EX boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctl_p1 <= '0;
      rd_p1  <= '0;
      vld_p1 <= 1'b0;
    end else if (bubble || !id_valid) begin
      ctl_p1 <= '0;
      rd_p1  <= '0;
      vld_p1 <= 1'b0;
    end else begin
      ctl_p1 <= ctl_p0;
      rd_p1  <= id_rd;
      vld_p1 <= 1'b1;
    end
  end

  // EX/MEM boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mctl_p2 <= '0;
      rd_p2   <= '0;
      vld_p2  <= 1'b0;
    end else begin
      mctl_p2 <= '{memread:  ctl_p1.memread,  memwrite: ctl_p1.memwrite,
                   memtoreg: ctl_p1.memtoreg, regwrite: ctl_p1.regwrite};
      rd_p2   <= rd_p1;
      vld_p2  <= vld_p1;
    end
  end

  // MEM/WB boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      memtoreg_p3 <= 1'b0;
      regwrite_p3 <= 1'b0;
      rd_p3       <= '0;
      vld_p3      <= 1'b0;
    end else begin
      memtoreg_p3 <= mctl_p2.memtoreg;
      regwrite_p3 <= mctl_p2.regwrite;
      rd_p3       <= rd_p2;
      vld_p3      <= vld_p2;
    end
  end

  assign ex_alusrc    = ctl_p1.alusrc;
  assign ex_aluop     = ctl_p1.aluop;
  assign ex_branch    = ctl_p1.branch;
  assign ex_jal       = ctl_p1.jal;
  assign ex_jalr      = ctl_p1.jalr;
  assign ex_lui       = ctl_p1.lui;
  assign ex_auipc     = ctl_p1.auipc;
  assign ex_illegal   = ctl_p1.illegal;
  assign ex_memread   = ctl_p1.memread;
  assign ex_memwrite  = ctl_p1.memwrite;
  assign ex_memtoreg  = ctl_p1.memtoreg;
  assign ex_regwrite  = ctl_p1.regwrite & vld_p1;
  assign ex_rd        = rd_p1;

  assign mem_memread  = mctl_p2.memread;
  assign mem_memwrite = mctl_p2.memwrite;
  assign mem_memtoreg = mctl_p2.memtoreg;
  assign mem_regwrite = mctl_p2.regwrite & vld_p2;
  assign mem_rd       = rd_p2;

  assign wb_memtoreg  = memtoreg_p3;
  assign wb_regwrite  = regwrite_p3 & vld_p3;
  assign wb_rd        = rd_p3;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: a decode table plus hand-written hazard,
// redirect and reset sequences on a LOAD_LAT=1 and a LOAD_LAT=3 instance.
module tb_ctrl_pipe;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // Control order: alusrc, aluop[1:0], branch, jal, jalr, lui, auipc, illegal,
  // memread, memwrite, memtoreg, regwrite
  localparam logic [12:0] C_R     = 13'b0_10_0_0_0_0_0_0_0_0_0_1;
  localparam logic [12:0] C_I     = 13'b1_10_0_0_0_0_0_0_0_0_0_1;
  localparam logic [12:0] C_LW    = 13'b1_00_0_0_0_0_0_0_1_0_1_1;
  localparam logic [12:0] C_SW    = 13'b1_00_0_0_0_0_0_0_0_1_0_0;
  localparam logic [12:0] C_BR    = 13'b0_01_1_0_0_0_0_0_0_0_0_0;
  localparam logic [12:0] C_JAL   = 13'b0_00_0_1_0_0_0_0_0_0_0_1;
  localparam logic [12:0] C_JALR  = 13'b1_00_0_0_1_0_0_0_0_0_0_1;
  localparam logic [12:0] C_LUI   = 13'b1_00_0_0_0_1_0_0_0_0_0_1;
  localparam logic [12:0] C_AUIPC = 13'b1_00_0_0_0_0_1_0_0_0_0_1;
  localparam logic [12:0] C_ILL   = 13'b0_00_0_0_0_0_0_1_0_0_0_0;

  typedef struct packed {
    logic       stall;
    logic       flush_ifid;
    logic       ex_alusrc;
    logic [1:0] ex_aluop;
    logic       ex_branch;
    logic       ex_jal;
    logic       ex_jalr;
    logic       ex_lui;
    logic       ex_auipc;
    logic       ex_illegal;
    logic       ex_memread;
    logic       ex_memwrite;
    logic       ex_memtoreg;
    logic       ex_regwrite;
    logic [4:0] ex_rd;
    logic       mem_memread;
    logic       mem_memwrite;
    logic       mem_memtoreg;
    logic       mem_regwrite;
    logic [4:0] mem_rd;
    logic       wb_memtoreg;
    logic       wb_regwrite;
    logic [4:0] wb_rd;
  } outs_t;

  typedef struct {
    string       nm;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [12:0] ctl;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       id_valid = 1'b0;
  logic [6:0] id_opcode = '0;
  logic [4:0] id_rs1 = '0;
  logic [4:0] id_rs2 = '0;
  logic [4:0] id_rd = '0;
  logic       ex_redirect = 1'b0;
  outs_t      o1;
  outs_t      o3;
  int         n_cmp = 0;
  int         n_bad = 0;
  vec_t       tv[10];

  always #5 clk = ~clk;

  ctrl_pipe #(.REG_W(5), .LOAD_LAT(1), .UPPER_EN(1)) u1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_redirect(ex_redirect),
    .stall(o1.stall), .flush_ifid(o1.flush_ifid),
    .ex_alusrc(o1.ex_alusrc), .ex_aluop(o1.ex_aluop), .ex_branch(o1.ex_branch),
    .ex_jal(o1.ex_jal), .ex_jalr(o1.ex_jalr), .ex_lui(o1.ex_lui),
    .ex_auipc(o1.ex_auipc), .ex_illegal(o1.ex_illegal),
    .ex_memread(o1.ex_memread), .ex_memwrite(o1.ex_memwrite),
    .ex_memtoreg(o1.ex_memtoreg), .ex_regwrite(o1.ex_regwrite), .ex_rd(o1.ex_rd),
    .mem_memread(o1.mem_memread), .mem_memwrite(o1.mem_memwrite),
    .mem_memtoreg(o1.mem_memtoreg), .mem_regwrite(o1.mem_regwrite),
    .mem_rd(o1.mem_rd), .wb_memtoreg(o1.wb_memtoreg),
    .wb_regwrite(o1.wb_regwrite), .wb_rd(o1.wb_rd)
  );

  ctrl_pipe #(.REG_W(5), .LOAD_LAT(3), .UPPER_EN(0)) u3 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_redirect(ex_redirect),
    .stall(o3.stall), .flush_ifid(o3.flush_ifid),
    .ex_alusrc(o3.ex_alusrc), .ex_aluop(o3.ex_aluop), .ex_branch(o3.ex_branch),
    .ex_jal(o3.ex_jal), .ex_jalr(o3.ex_jalr), .ex_lui(o3.ex_lui),
    .ex_auipc(o3.ex_auipc), .ex_illegal(o3.ex_illegal),
    .ex_memread(o3.ex_memread), .ex_memwrite(o3.ex_memwrite),
    .ex_memtoreg(o3.ex_memtoreg), .ex_regwrite(o3.ex_regwrite), .ex_rd(o3.ex_rd),
    .mem_memread(o3.mem_memread), .mem_memwrite(o3.mem_memwrite),
    .mem_memtoreg(o3.mem_memtoreg), .mem_regwrite(o3.mem_regwrite),
    .mem_rd(o3.mem_rd), .wb_memtoreg(o3.wb_memtoreg),
    .wb_regwrite(o3.wb_regwrite), .wb_rd(o3.wb_rd)
  );

  function automatic logic [12:0] exctl(input outs_t o);
    return {o.ex_alusrc, o.ex_aluop, o.ex_branch, o.ex_jal, o.ex_jalr, o.ex_lui,
            o.ex_auipc, o.ex_illegal, o.ex_memread, o.ex_memwrite, o.ex_memtoreg,
            o.ex_regwrite};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [6:0] op, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd);
    id_valid  = v;
    id_opcode = op;
    id_rs1    = rs1;
    id_rs2    = rs2;
    id_rd     = rd;
  endtask

  task automatic do_reset();
    set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    ex_redirect = 1'b0;
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  initial begin
    int ns;
    int nb;
    tv[0] = '{"r",     OP_R,     5'd1,  C_R};
    tv[1] = '{"i",     OP_I,     5'd2,  C_I};
    tv[2] = '{"lw",    OP_LW,    5'd3,  C_LW};
    tv[3] = '{"sw",    OP_SW,    5'd4,  C_SW};
    tv[4] = '{"br",    OP_BR,    5'd5,  C_BR};
    tv[5] = '{"jal",   OP_JAL,   5'd6,  C_JAL};
    tv[6] = '{"jalr",  OP_JALR,  5'd7,  C_JALR};
    tv[7] = '{"lui",   OP_LUI,   5'd8,  C_LUI};
    tv[8] = '{"auipc", OP_AUIPC, 5'd9,  C_AUIPC};
    tv[9] = '{"ill",   7'd0,     5'd0,  C_ILL};

    #12;
    check("reset_u1_all", 64'(o1), 64'd0);
    check("reset_u3_all", 64'(o3), 64'd0);
    reset = 1'b1;
    tick();

    // Decode sweep on the UPPER_EN=1 instance
    for (int i = 0; i < 10; i++) begin
      set_id(1'b1, tv[i].op, 5'd0, 5'd0, tv[i].rd);
      tick();
      check({"dec_", tv[i].nm, "_ctl"}, 64'(exctl(o1)), 64'(tv[i].ctl));
      check({"dec_", tv[i].nm, "_rd"},  64'(o1.ex_rd),  64'(tv[i].rd));
    end

    // LUI is illegal with UPPER_EN=0
    do_reset();
    set_id(1'b1, OP_LUI, 5'd0, 5'd0, 5'd8);
    tick();
    check("lui_upper_off", 64'(exctl(o3)), 64'(C_ILL));

    // Load-use, LOAD_LAT=1
    do_reset();
    set_id(1'b1, OP_LW, 5'd1, 5'd0, 5'd5);
    #1 check("lu1_lw_nostall", 64'(o1.stall), 64'd0);
    tick();
    set_id(1'b1, OP_R, 5'd5, 5'd1, 5'd6);
    #1 check("lu1_stall", 64'(o1.stall), 64'd1);
    tick();
    check("lu1_stall_drop", 64'(o1.stall), 64'd0);
    check("lu1_bubble", 64'({o1.ex_regwrite, o1.ex_memread, o1.ex_rd}), 64'd0);
    check("lu1_mem_lw", 64'({o1.mem_memread, o1.mem_rd}), 64'({1'b1, 5'd5}));
    tick();
    set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    check("lu1_add_ex", 64'({o1.ex_regwrite, o1.ex_rd}), 64'({1'b1, 5'd6}));
    check("lu1_lw_wb", 64'({o1.wb_memtoreg, o1.wb_regwrite, o1.wb_rd}),
          64'({1'b1, 1'b1, 5'd5}));

    // Load-use, LOAD_LAT=3
    do_reset();
    set_id(1'b1, OP_LW, 5'd1, 5'd0, 5'd5);
    tick();
    set_id(1'b1, OP_R, 5'd5, 5'd1, 5'd6);
    ns = 0;
    nb = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (!o3.stall) break;
      ns++;
      tick();
      if (!o3.ex_regwrite && !o3.ex_memread && o3.ex_rd == 5'd0) nb++;
    end
    check("lu3_stall_cycles", 64'(ns), 64'd3);
    check("lu3_bubbles", 64'(nb), 64'd3);
    check("lu3_release", 64'(o3.stall), 64'd0);
    tick();
    check("lu3_add_ex", 64'({o3.ex_regwrite, o3.ex_rd}), 64'({1'b1, 5'd6}));

    // Store data dependent on the load still stalls
    do_reset();
    set_id(1'b1, OP_LW, 5'd1, 5'd0, 5'd5);
    tick();
    set_id(1'b1, OP_SW, 5'd1, 5'd5, 5'd0);
    #1 check("sw_rs2_stall", 64'(o1.stall), 64'd1);

    // No-hazard cases
    do_reset();
    set_id(1'b1, OP_LW, 5'd1, 5'd0, 5'd0);
    tick();
    set_id(1'b1, OP_R, 5'd0, 5'd0, 5'd6);
    #1 check("x0_nostall", 64'(o3.stall), 64'd0);
    tick();
    set_id(1'b1, OP_LW, 5'd1, 5'd0, 5'd5);
    tick();
    set_id(1'b1, OP_JAL, 5'd5, 5'd5, 5'd5);
    #1 check("jal_nostall", 64'(o3.stall), 64'd0);
    tick();
    check("jal_ex", 64'({o3.ex_jal, o3.ex_rd}), 64'({1'b1, 5'd5}));

    // Hazard and redirect together resolve as a redirect
    do_reset();
    set_id(1'b1, OP_LW, 5'd1, 5'd0, 5'd5);
    tick();
    set_id(1'b1, OP_R, 5'd5, 5'd1, 5'd6);
    ex_redirect = 1'b1;
    #1 check("hzrd_flags", 64'({o1.stall, o1.flush_ifid}), 64'b01);
    tick();
    ex_redirect = 1'b0;
    check("hzrd_bubble", 64'({o1.ex_regwrite, o1.ex_rd}), 64'd0);

    // Redirect during the second cycle of a LOAD_LAT=3 hold
    do_reset();
    set_id(1'b1, OP_LW, 5'd1, 5'd0, 5'd5);
    tick();
    set_id(1'b1, OP_R, 5'd5, 5'd1, 5'd6);
    #1 check("rdh_stall1", 64'(o3.stall), 64'd1);
    tick();
    ex_redirect = 1'b1;
    #1 check("rdh_flags", 64'({o3.stall, o3.flush_ifid}), 64'b01);
    tick();
    ex_redirect = 1'b0;
    set_id(1'b1, OP_I, 5'd2, 5'd0, 5'd7);
    #1 check("rdh_run", 64'(o3.stall), 64'd0);
    tick();
    check("rdh_dec_ctl", 64'(exctl(o3)), 64'(C_I));
    check("rdh_dec_rd", 64'(o3.ex_rd), 64'd7);

    // Asynchronous reset with a load in MEM and HOLD active
    do_reset();
    set_id(1'b1, OP_LW, 5'd1, 5'd0, 5'd5);
    tick();
    set_id(1'b1, OP_R, 5'd5, 5'd1, 5'd6);
    tick();
    #1 check("rm_pre_state", 64'({o3.stall, o3.mem_memread, o3.mem_rd}),
             64'({1'b1, 1'b1, 5'd5}));
    reset = 1'b0;
    #1;
    check("rm_u3_zero", 64'(o3), 64'd0);
    check("rm_u1_zero", 64'(o1), 64'd0);
    set_id(1'b1, OP_SW, 5'd1, 5'd2, 5'd0);
    #1 reset = 1'b1;
    #1 check("rm_nostall", 64'(o3.stall), 64'd0);
    tick();
    check("rm_first_dec", 64'(exctl(o3)), 64'(C_SW));
    set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Pipelined control unit for the five-stage RISC-V core. It decodes the ID-stage opcode into the control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB stage registers. It also detects load-use hazards, holding the front end for a parametrised number of cycles, and squashes the wrong-path instruction on a taken branch or jump. It replaces the combinational decoder plus the scattered per-stage control flops in the datapath.

## Interface
- `REG_W`, 5: register-address width.
- `LOAD_LAT`, 1: bubbles inserted per load-use hazard. Legal range 1..3.
- `UPPER_EN`, 1: 1 decodes LUI (0110111) and AUIPC (0010111); 0 treats them as illegal.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `id_valid`  in  1  ID holds a real instruction
- `id_opcode`  in  7  ID instruction[6:0]
- `id_rs1`, `id_rs2`, `id_rd`  in  REG_W each  ID register fields
- `ex_redirect`  in  1  EX resolved a taken branch, JAL or JALR this cycle
- `stall`  out  1  hold PC and IF/ID this cycle
- `flush_ifid`  out  1  turn IF/ID into a bubble at the next edge
- `ex_alusrc`, `ex_aluop[1:0]`, `ex_branch`, `ex_jal`, `ex_jalr`, `ex_lui`, `ex_auipc`, `ex_illegal`  out  EX-stage controls
- `ex_memread`, `ex_memwrite`, `ex_memtoreg`, `ex_regwrite`  out  1 each  EX copies
- `ex_rd`  out  REG_W
- `mem_memread`, `mem_memwrite`, `mem_memtoreg`, `mem_regwrite`  out  1 each; `mem_rd`  out  REG_W
- `wb_memtoreg`, `wb_regwrite`  out  1 each; `wb_rd`  out  REG_W

## Operation
**Decode** (combinational, ID stage):
- R_TYPE 0110011: regwrite; aluop 10.
- I_TYPE 0010011: alusrc, regwrite; aluop 10.
- LW 0000011: alusrc, memread, memtoreg, regwrite; aluop 00.
- SW 0100011: alusrc, memwrite; aluop 00.
- BR 1100011: branch; aluop 01.
- JAL 1101111: jal, regwrite.
- JALR 1100111: jalr, alusrc, regwrite.
- LUI / AUIPC (UPPER_EN=1 only): lui or auipc, alusrc, regwrite; aluop 00.
- Any other opcode: illegal=1, all other controls 0.

**Register use:**
- rs1 is used by R, I, LW, SW, BR and JALR.
- rs2 is used by R, SW and BR.

**Bubble** = every control 0, rd 0, illegal 0. An instruction with `id_valid`=0 decodes as a bubble.

**Load-use hazard** (`hz`), all of the following:
- `ex_memread`=1
- `ex_rd`≠0
- `id_valid`=1
- `ex_rd` equals a used rs1 or a used rs2

**FSM states:**
- RUN:
  - `stall`=`hz`.
  - If `hz`: a bubble enters EX. Go to HOLD with cnt=LOAD_LAT−1 if LOAD_LAT>1, otherwise stay in RUN.
- HOLD:
  - `stall`=1 and a bubble enters EX.
  - cnt decrements each cycle.
  - When cnt=1, return to RUN at the next edge.
- A LOAD_LAT-cycle hold therefore always yields exactly LOAD_LAT bubbles.

**Redirect** (`ex_redirect`=1):
- `flush_ifid`=1 and `stall`=0 combinationally, overriding `hz` and HOLD.
- A bubble enters EX.
- The FSM goes to RUN at the next edge.

**Stage advance:**
- EX/MEM and MEM/WB always advance.
- MEM takes EX's memory/writeback fields; WB takes MEM's.

## Timing
- Decode to `ex_*` takes one edge. `mem_*` follows 2 edges after ID; `wb_*` follows 3 edges after ID.
- `stall` and `flush_ifid` are combinational from current inputs and state, valid before the next rising edge.
- **Reset** (asserted at any time, asynchronous):
  - All stage outputs become 0 and the FSM goes to RUN with cnt=0.
  - `stall` and `flush_ifid` read 0 unless `ex_redirect` is driven.
  - Instructions in flight are discarded.
- **Release:** the first edge after `reset` rises samples ID normally.
- A simultaneous `hz` and `ex_redirect` resolves as a redirect.
- A load into x0 never stalls.
- A store whose rs2 equals the load's rd stalls; there is no MEM-to-MEM forwarding.

## Test plan
- **Decode sweep**, UPPER_EN=1: drive all 9 legal opcodes plus 0000000.
  - `ex_*` must match the decode list one cycle later.
  - 0000000 gives `ex_illegal`=1 with every other control 0.
  - With UPPER_EN=0, LUI gives `ex_illegal`=1.
- **Load-use**, LOAD_LAT=1: drive `lw x5` then `add x6,x5,x1`.
  - `stall`=1 for exactly 1 cycle.
  - A single EX bubble follows, then `ex_rd`=6 and `ex_regwrite`=1.
  - The load reaches `wb_rd`=5 with `wb_memtoreg`=1 three edges after its ID cycle.
- **Load-use**, LOAD_LAT=3: drive the same pair.
  - `stall` is high for 3 consecutive cycles.
  - 3 bubbles are inserted.
  - No `stall` on the following cycle.
- **No-hazard cases:** drive `lw x0`, then a dependent `add` on x0 → `stall` never asserts. Drive `lw x5`, then `jal x5` → no stall, since JAL uses neither rs1 nor rs2.
- **Redirect mid-hold**, LOAD_LAT=3: assert `ex_redirect` during the 2nd stall cycle.
  - That cycle shows `stall`=0 and `flush_ifid`=1.
  - The FSM is in RUN at the next edge.
  - `id_valid`=1 with a new opcode decodes normally the following cycle.
- **Reset mid-operation:** drop `reset` asynchronously while a load is in MEM and HOLD is active.
  - Every output reads 0 without a clock edge.
  - After release, the first instruction decodes correctly.
